mac_sched: RTL and testbench

Tile scheduler for the CNN MAC array. It accepts a job (filter base, input base, output base, tile count) and, for each tile, clears the MACs, streams the shared X operand to all MACs, then streams the Y operands to each MAC in turn. It then waits for the array to finish and writes one result per MAC back to memory through a valid/ready port. It sits between the top-level controller and the buffer memory / MAC array, and replaces free-running address generation with a start/done-controlled sequence.

---
 rtl/mac_sched_pkg.sv | 9 +
 rtl/mac_sched_adr_cnt.sv | 19 +
 rtl/mac_sched.sv | 157 +++++++++++++++
 tb/tb_mac_sched.sv | 109 ++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared state encoding, widths and wr_sel helper for the MAC tile scheduler.
package mac_sched_pkg;
  localparam int ADR_W = 8;
  localparam int SEL_W = 4;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_X, LOAD_Y, DRAIN, COMPUTE, WRITE, DONE} state_t;
  function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] k);
    return k + 1'b1;
  endfunction
endpackage

// File: rtl/mac_sched_adr_cnt.sv
// mac_sched_adr_cnt: 8-bit address generator that loads a base and steps by one, wrapping mod 256.
module mac_sched_adr_cnt
  import mac_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [ADR_W-1:0] base,
  output logic [ADR_W-1:0] adr
);
  logic [ADR_W-1:0] adr_q, adr_d;
  always_comb adr_d = load ? base : inc ? adr_q + 1'b1 : adr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) adr_q <= '0;
    else adr_q <= adr_d;
  end
  assign adr = adr_q;
endmodule

// File: rtl/mac_sched.sv
// mac_sched: start/done tile scheduler sequencing clear, X/Y operand loads, compute and result writeback.
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int MAC_COUNT = 4,
  parameter int X_LEN     = 64,
  parameter int Y_PER_MAC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADR_W-1:0]     adr_x,
  input  logic [ADR_W-1:0]     adr_y,
  input  logic [ADR_W-1:0]     adr_out,
  input  logic [ADR_W-1:0]     tiles,
  output logic [ADR_W-1:0]     rd_adr,
  output logic [MAC_COUNT-1:0] ld_en,
  output logic                 ld_x,
  output logic                 mac_clr,
  output logic                 mac_go,
  input  logic [MAC_COUNT-1:0] mac_done,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADR_W-1:0]     wr_adr,
  output logic [SEL_W-1:0]     wr_sel,
  output logic                 busy,
  output logic                 done
);
  localparam int CNT_W = 16;
  localparam int YN    = MAC_COUNT * Y_PER_MAC;
  state_t state_q, state_d;
  logic [ADR_W-1:0] x_base_q, x_base_d, y_base_q, y_base_d, out_base_q, out_base_d, tiles_q, tiles_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] k_q, k_d;
  logic [MAC_COUNT-1:0] ld_en_q, ld_en_d;
  logic ld_x_q, ld_x_d, mac_clr_q, mac_go_q, wr_valid_q, busy_q, done_q;
  logic rd_load, rd_inc, wr_load, wr_inc, hs;
  logic [ADR_W-1:0] rd_base;
  assign hs = wr_valid_q && wr_ready;
  always_comb begin
    state_d    = state_q;
    x_base_d   = x_base_q;
    y_base_d   = y_base_q;
    out_base_d = out_base_q;
    tiles_d    = tiles_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    ld_en_d    = '0;
    ld_x_d     = 1'b0;
    rd_load    = 1'b0;
    rd_inc     = 1'b0;
    rd_base    = x_base_q;
    wr_load    = 1'b0;
    wr_inc     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = (tiles == 8'd0) ? DONE : CLEAR;
        if (tiles != 8'd0) begin
          x_base_d   = adr_x;
          y_base_d   = adr_y;
          out_base_d = adr_out;
          tiles_d    = tiles;
        end
      end
      CLEAR: begin
        state_d = LOAD_X;
        cnt_d   = '0;
        rd_load = 1'b1;
      end
      LOAD_X: begin
        ld_en_d = '1;
        ld_x_d  = 1'b1;
        if (cnt_q == CNT_W'(X_LEN - 1)) begin
          state_d = LOAD_Y;
          cnt_d   = '0;
          rd_load = 1'b1;
          rd_base = y_base_q;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          rd_inc = 1'b1;
        end
      end
      LOAD_Y: begin
        // Y words go to one MAC at a time, Y_PER_MAC consecutive words each
        ld_en_d = MAC_COUNT'(1) << (cnt_q / CNT_W'(Y_PER_MAC));
        if (cnt_q == CNT_W'(YN - 1)) state_d = DRAIN;
        else begin
          cnt_d  = cnt_q + 1'b1;
          rd_inc = 1'b1;
        end
      end
      DRAIN: state_d = COMPUTE;
      COMPUTE: if (&mac_done) begin
        state_d = WRITE;
        k_d     = '0;
        wr_load = 1'b1;
      end
      WRITE: if (hs) begin
        if (k_q == SEL_W'(MAC_COUNT - 1)) begin
          tiles_d    = tiles_q - 1'b1;
          y_base_d   = y_base_q + ADR_W'(YN);
          out_base_d = out_base_q + ADR_W'(MAC_COUNT);
          state_d    = (tiles_q == 8'd1) ? DONE : CLEAR;
        end else begin
          k_d    = sel_next(k_q);
          wr_inc = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      x_base_q   <= '0;
      y_base_q   <= '0;
      out_base_q <= '0;
      tiles_q    <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      ld_en_q    <= '0;
      ld_x_q     <= 1'b0;
      mac_clr_q  <= 1'b0;
      mac_go_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_base_q   <= x_base_d;
      y_base_q   <= y_base_d;
      out_base_q <= out_base_d;
      tiles_q    <= tiles_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      ld_en_q    <= ld_en_d;
      ld_x_q     <= ld_x_d;
      mac_clr_q  <= state_d == CLEAR;
      mac_go_q   <= state_d == COMPUTE;
      wr_valid_q <= state_d == WRITE;
      busy_q     <= state_d != IDLE;
      done_q     <= state_d == DONE;
    end
  end
  mac_sched_adr_cnt u_rd (.clk(clk), .rst(rst), .load(rd_load), .inc(rd_inc), .base(rd_base), .adr(rd_adr));
  mac_sched_adr_cnt u_wr (.clk(clk), .rst(rst), .load(wr_load), .inc(wr_inc), .base(out_base_q), .adr(wr_adr));
  assign ld_en    = ld_en_q;
  assign ld_x     = ld_x_q;
  assign mac_clr  = mac_clr_q;
  assign mac_go   = mac_go_q;
  assign wr_valid = wr_valid_q;
  assign wr_sel   = k_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: table-driven job vectors plus async-reset and busy-start sequences for mac_sched.
module tb_mac_sched;
  localparam int X_LEN = 64;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, ld_x, mac_clr, mac_go, wr_valid, wr_ready = 1'b1, busy, done;
  logic [7:0] adr_x = '0, adr_y = '0, adr_out = '0, tiles_i = '0, rd_adr, wr_adr;
  logic [3:0] ld_en, mac_done = '0, wr_sel;
  int tests = 0, fails = 0;

  typedef struct {
    logic [7:0] tiles, ax, ay, ao;
    bit         bp, flick;
    int         w, cyc, loads, writes;
    logic [7:0] last_x, last_y, last_wr;
  } vec_t;
  vec_t vecs[5];

  mac_sched dut (
    .clk(clk), .rst(rst), .start(start), .adr_x(adr_x), .adr_y(adr_y), .adr_out(adr_out),
    .tiles(tiles_i), .rd_adr(rd_adr), .ld_en(ld_en), .ld_x(ld_x), .mac_clr(mac_clr),
    .mac_go(mac_go), .mac_done(mac_done), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_adr(wr_adr), .wr_sel(wr_sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int cyc = 1, ln = 0, ti = 0, loads = 0, wc = 0, wcyc = 0, gc = 0, clrs = 0;
    logic [7:0] prev_rd, lx = '0, ly = '0, lw = '0, ea;
    logic [3:0] een;
    bit ok = 0;
    tiles_i = v.tiles; adr_x = v.ax; adr_y = v.ay; adr_out = v.ao;
    wr_ready = !v.bp; mac_done = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_rd = rd_adr;
    while (cyc < 2000) begin
      if (done) begin ok = 1; break; end
      chk("busy", busy, 1);
      if (mac_clr) clrs++;
      if (ld_en != 0) begin
        if (ln < X_LEN) begin ea = v.ax + 8'(ln); een = 4'hF; end
        else begin ea = v.ay + 8'(ti * 16 + ln - X_LEN); een = 4'(1 << ((ln - X_LEN) / 4)); end
        chk("load", {ld_en, ld_x, prev_rd}, {een, ln < X_LEN, ea});
        if (ld_x) lx = prev_rd; else ly = prev_rd;
        loads++; ln++;
        if (ln == X_LEN + 16) begin ln = 0; ti++; end
      end
      prev_rd = rd_adr;
      if (wr_valid) begin
        chk("write", {wr_sel, wr_adr}, {4'(wc % 4), v.ao + 8'(wc)});
        lw = wr_adr;
        wr_ready = v.bp ? (wcyc % 2 == 1) : 1'b1;
        wcyc++;
        if (wr_ready) wc++;
      end else wr_ready = !v.bp;
      gc = mac_go ? gc + 1 : 0;
      mac_done = ((mac_go && gc > v.w) || (v.flick && ld_x)) ? 4'hF : 4'h0;
      start = (cyc == 40);
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", ok, 1);
    chk("cycles", cyc, v.cyc);
    chk("loads", loads, v.loads);
    chk("writes", wc, v.writes);
    chk("clears", clrs, v.tiles);
    chk("last_adrs", {lx, ly, lw}, {v.last_x, v.last_y, v.last_wr});
    mac_done = '0; wr_ready = 1'b1; tiles_i = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", {busy, done}, 0);
    @(negedge clk);
    chk("start_ignored", {busy, mac_clr}, 0);
  endtask

  initial begin
    vecs[0] = '{8'd1, 8'h10, 8'h80, 8'h20, 0, 0, 0, 88, 80, 4, 8'h4F, 8'h8F, 8'h23};
    vecs[1] = '{8'd1, 8'hF0, 8'hF8, 8'hFE, 0, 0, 3, 91, 80, 4, 8'h2F, 8'h07, 8'h01};
    vecs[2] = '{8'd1, 8'h00, 8'h40, 8'h30, 1, 1, 1, 93, 80, 4, 8'h3F, 8'h4F, 8'h33};
    vecs[3] = '{8'd3, 8'h20, 8'h00, 8'h40, 0, 0, 2, 268, 240, 12, 8'h5F, 8'h2F, 8'h4B};
    vecs[4] = '{8'd0, 8'h55, 8'h66, 8'h77, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00};
    repeat (2) @(negedge clk);
    chk("reset_outputs", {rd_adr, ld_en, ld_x, mac_clr, mac_go, wr_valid, wr_adr, wr_sel, busy, done}, 0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run(vecs[i]);
    tiles_i = 8'd2; adr_x = 8'h10; adr_y = 8'h80; adr_out = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && !(ld_en != 0 && !ld_x); i++) @(negedge clk);
    chk("reach_load_y", {ld_en != 0, ld_x}, 2'b10);
    #2 rst = 1'b0;
    #1 chk("async_reset", {rd_adr, ld_en, ld_x, mac_clr, mac_go, wr_valid, wr_adr, wr_sel, busy, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(vecs[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
